data_mem_bridge: RTL

//  Sits directly downstream of the CPU data port (port 2).

---
 rtl/data_mem_bridge.sv | 130 +++++++++++++
 1 files changed

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - CPU data-port decoder: RAM below 0x400, MMIO block above.
// MMIO reads are registered so both regions return data with one cycle of latency.
module data_mem_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 10,
  parameter int SW_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       cpu_addr,
  input  logic              cpu_w_en,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic [9:0]        ram_addr,
  output logic              ram_w_en,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [9:0] A_LED  = 10'd0;
  localparam logic [9:0] A_SW   = 10'd1;
  localparam logic [9:0] A_CNT  = 10'd2;
  localparam logic [9:0] A_TXD  = 10'd3;
  localparam logic [9:0] A_STAT = 10'd4;

  logic            is_io;
  logic            io_wr;
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic [LED_W-1:0] led_q;
  logic [31:0]     cnt_q;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            sel_q;
  logic [31:0]     io_q;
  logic [31:0]     io_val;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            push_ok;

  assign is_io     = cpu_addr[10];
  assign io_wr     = cpu_w_en & is_io;
  assign ram_addr  = cpu_addr[9:0];
  assign ram_w_en  = cpu_w_en & ~is_io;
  assign ram_wdata = cpu_wdata;
  assign cpu_rdata = sel_q ? io_q : ram_rdata;
  assign led_out   = led_q;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  assign push     = io_wr & (cpu_addr[9:0] == A_TXD);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push & (~full | pop);

  always_comb begin
    io_val = '0;
    case (cpu_addr[9:0])
      A_LED:  io_val = 32'(led_q);
      A_SW:   io_val = 32'(sw_sync);
      A_CNT:  io_val = cnt_q;
      A_STAT: begin
        io_val[0]       = empty;
        io_val[1]       = full;
        io_val[2]       = overflow;
        io_val[8 +: CW] = count;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      sel_q    <= 1'b1;
      io_q     <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      sel_q   <= is_io;
      io_q    <= io_val;
      if (io_wr && cpu_addr[9:0] == A_LED)
        led_q <= cpu_wdata[LED_W-1:0];
      if (io_wr && cpu_addr[9:0] == A_CNT)
        cnt_q <= cpu_wdata;
      else
        cnt_q <= cnt_q + 32'd1;
      if (io_wr && cpu_addr[9:0] == A_STAT)
        overflow <= 1'b0;
      else if (push && !push_ok)
        overflow <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= cpu_wdata[7:0];
  end
endmodule
